// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use stall, memory-wait FSM with timeout, perf counters.
// Latency: control outputs are combinational from inputs and registered FSM state. Backpressure: a memory wait stalls F/D/E/M and bubbles W.
// Reset is asynchronous and active-high; while it is held every output reads zero.
module hazard_unit_mc #(
    parameter int REG_AW   = 5,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              PCSrcE,
    input  logic              ResultSrcb0E,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemTimeout,
    output logic [CNT_W-1:0]  LoadUseCnt,
    output logic [CNT_W-1:0]  MemStallCnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    // The counter enters WAIT at 1 and stalls through WAIT_MAX, so timeout fires one count later.
    localparam int WCW = $clog2(WAIT_MAX + 2);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(WAIT_MAX + 1);

    logic [0:0]     state, stateNext;
    logic [WCW-1:0] waitCnt, waitCntNext;
    logic           memStall, timeoutPulse, lwStall;
    logic [1:0]     fwdA, fwdB;

    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs);
        if (RegWriteM && (RdM != '0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwdA    = fwdSel(Rs1E);
    assign fwdB    = fwdSel(Rs2E);
    assign lwStall = ResultSrcb0E && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        stateNext    = state;
        waitCntNext  = waitCnt;
        memStall     = 1'b0;
        timeoutPulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    memStall    = 1'b1;
                    stateNext   = ST_WAIT;
                    waitCntNext = WCW'(1);
                end
            end
            default: begin
                if (MemReadyM) begin
                    stateNext   = ST_IDLE;
                    waitCntNext = '0;
                end else if (waitCnt == WAIT_LIMIT) begin
                    timeoutPulse = 1'b1;
                    stateNext    = ST_IDLE;
                    waitCntNext  = '0;
                end else begin
                    memStall    = 1'b1;
                    waitCntNext = waitCnt + WCW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            waitCnt     <= '0;
            LoadUseCnt  <= '0;
            MemStallCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (lwStall && !memStall && (LoadUseCnt != '1))
                LoadUseCnt <= LoadUseCnt + CNT_W'(1);
            if (memStall && (MemStallCnt != '1))
                MemStallCnt <= MemStallCnt + CNT_W'(1);
        end
    end

    // A pending memory access dominates: the branch stays in E and flushes once released.
    assign ForwardAE  = reset ? 2'b00 : fwdA;
    assign ForwardBE  = reset ? 2'b00 : fwdB;
    assign StallM     = !reset && memStall;
    assign StallE     = !reset && memStall;
    assign FlushW     = !reset && memStall;
    assign StallF     = !reset && (memStall || lwStall);
    assign StallD     = !reset && (memStall || lwStall);
    assign FlushE     = !reset && !memStall && (lwStall || PCSrcE);
    assign FlushD     = !reset && !memStall && PCSrcE;
    assign MemTimeout = !reset && timeoutPulse;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc with WAIT_MAX=4 and CNT_W=4 so timeout and saturation are reachable quickly.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       PCSrcE, ResultSrcb0E, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [3:0] LoadUseCnt, MemStallCnt;

    int nVec = 0;
    int nErr = 0;

    hazard_unit_mc #(.REG_AW(5), .WAIT_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .PCSrcE(PCSrcE), .ResultSrcb0E(ResultSrcb0E), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout),
        .LoadUseCnt(LoadUseCnt), .MemStallCnt(MemStallCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       rwM, rwW, ldE, pcSrc;
        logic [1:0] fA, fB;
        logic       stl, flD, flE;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setIdle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        PCSrcE = 0; ResultSrcb0E = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        setIdle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // {StallF, StallD, StallE, StallM, FlushW}
    function automatic logic [4:0] memGrp();
        return {StallF, StallD, StallE, StallM, FlushW};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int expLu;
        int expMs;
        //          rs1D rs2D rs1E rs2E rdE rdM rdW rwM rwW ld pc | fA fB stl flD flE
        vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 2'd2, 2'd0, 0, 0, 0};
        vecs[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0};
        vecs[2]  = '{0, 0, 3, 7, 0, 7, 3, 1, 1, 0, 0, 2'd1, 2'd2, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0};
        vecs[4]  = '{0, 0, 9, 9, 0, 9, 9, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0};
        vecs[5]  = '{0, 3, 0, 0, 3, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 1, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 1, 1};
        vecs[8]  = '{4, 0, 0, 0, 4, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 1, 1, 1};
        vecs[9]  = '{1, 2, 0, 0, 6, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0};
        vecs[10] = '{8, 0, 8, 0, 8, 8, 0, 1, 0, 1, 0, 2'd2, 2'd0, 1, 0, 1};

        // Reset state with inputs that would otherwise forward, stall and flush
        setIdle();
        reset = 1'b1;
        RegWriteM = 1; RdM = 5; Rs1E = 5; Rs2E = 5; PCSrcE = 1;
        ResultSrcb0E = 1; RdE = 3; Rs1D = 3; MemReqM = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout}, 0);
        chk("reset_counters", {LoadUseCnt, MemStallCnt}, 0);
        setIdle();
        reset = 1'b0;

        // Combinational table, no memory request
        expLu = 0;
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
            RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW;
            RegWriteM = vecs[i].rwM; RegWriteW = vecs[i].rwW;
            ResultSrcb0E = vecs[i].ldE; PCSrcE = vecs[i].pcSrc;
            @(negedge clk);
            chk($sformatf("v%0d_fwdA", i), ForwardAE, vecs[i].fA);
            chk($sformatf("v%0d_fwdB", i), ForwardBE, vecs[i].fB);
            chk($sformatf("v%0d_stallFD", i), {StallF, StallD}, {vecs[i].stl, vecs[i].stl});
            chk($sformatf("v%0d_flushD", i), FlushD, vecs[i].flD);
            chk($sformatf("v%0d_flushE", i), FlushE, vecs[i].flE);
            chk($sformatf("v%0d_memgrp", i), {StallE, StallM, FlushW, MemTimeout}, 0);
            chk($sformatf("v%0d_luCnt", i), LoadUseCnt, expLu);
            expLu += vecs[i].stl;
        end
        @(posedge clk); #1;
        setIdle();
        chk("luCnt_final", LoadUseCnt, expLu);

        // Memory wait: three not-ready cycles then ready
        doReset();
        MemReqM = 1; MemReadyM = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("mw_stall_c%0d", c), memGrp(), 5'b11111);
            @(posedge clk); #1;
        end
        MemReadyM = 1;
        @(negedge clk);
        chk("mw_ready_cycle", {memGrp(), MemTimeout}, 6'b0);
        @(posedge clk); #1;
        MemReqM = 0; MemReadyM = 0;
        chk("mw_stall_cnt", MemStallCnt, 3);

        // Branch held in E during a memory stall flushes only once released
        PCSrcE = 1; MemReqM = 1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("br_suppressed_c%0d", c), {FlushD, FlushE, FlushW}, 3'b001);
            @(posedge clk); #1;
        end
        MemReadyM = 1;
        @(negedge clk);
        chk("br_release_flush", {FlushD, FlushE, StallF, FlushW}, 4'b1100);
        @(posedge clk); #1;
        setIdle();
        chk("br_stall_cnt", MemStallCnt, 5);

        // Timeout: WAIT_MAX=4 gives five stall cycles, then the pulse on cycle six
        doReset();
        MemReqM = 1; MemReadyM = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("to_stall_c%0d", c), {memGrp(), MemTimeout}, 6'b111110);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_pulse_c6", {memGrp(), MemTimeout}, 6'b000001);
        @(posedge clk); #1;
        MemReqM = 0;
        @(negedge clk);
        chk("to_idle_c7", {memGrp(), MemTimeout}, 6'b0);
        chk("to_stall_cnt", MemStallCnt, 5);
        @(posedge clk); #1;
        // A fresh request after timeout must re-enter from IDLE with the full budget
        MemReqM = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("to_rearm_c%0d", c), {StallM, MemTimeout}, 2'b10);
            @(posedge clk); #1;
        end

        // Asynchronous reset while in WAIT
        doReset();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        repeat (2) @(posedge clk);
        #3;
        chk("rw_pre_stall", memGrp(), 5'b11111);
        reset = 1'b1;
        #1;
        chk("rw_async_out", {memGrp(), FlushD, FlushE, MemTimeout}, 0);
        chk("rw_async_cnt", MemStallCnt, 0);
        @(posedge clk); #1;
        setIdle();
        reset = 1'b0;
        @(negedge clk);
        chk("rw_idle_after", {memGrp(), MemTimeout}, 0);

        // Saturation: requests never answered; expected stall pattern repeats every 6 cycles
        doReset();
        MemReqM = 1; MemReadyM = 0;
        expMs = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk($sformatf("sat_stall_k%0d", k), {StallM, MemTimeout},
                ((k % 6) < 5) ? 2'b10 : 2'b01);
            if ((k % 6) < 5 && expMs < 15) expMs++;
            @(posedge clk); #1;
        end
        setIdle();
        chk("sat_cnt_model", MemStallCnt, expMs);
        chk("sat_cnt_allones", MemStallCnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
